// File: rtl/alu_issue_stage.sv
// Execute-issue stage: decodes INSTR into ALU operands/opcode and buffers them in a 2-entry skid buffer.
// Optional: define ILLEGAL_INSN_TRAP_EN to add the ILLEGAL output flag for undecodable instructions.
module alu_issue_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int OPRN_WIDTH     = 6,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      FLUSH,
    input  logic                      IN_VALID,
    output logic                      IN_READY,
    input  logic [31:0]               INSTR,
    input  logic [DATA_WIDTH-1:0]     RS_DATA,
    input  logic [DATA_WIDTH-1:0]     RT_DATA,
    output logic                      OUT_VALID,
    input  logic                      OUT_READY,
    output logic [DATA_WIDTH-1:0]     OP1,
    output logic [DATA_WIDTH-1:0]     OP2,
    output logic [OPRN_WIDTH-1:0]     OPRN,
    output logic [REG_ADDR_WIDTH-1:0] WB_ADDR,
    output logic                      WB_EN
`ifdef ILLEGAL_INSN_TRAP_EN
    ,
    output logic                      ILLEGAL
`endif
);

    typedef struct packed {
        logic                      valid;
        logic [DATA_WIDTH-1:0]     op1;
        logic [DATA_WIDTH-1:0]     op2;
        logic [OPRN_WIDTH-1:0]     oprn;
        logic [REG_ADDR_WIDTH-1:0] wb_addr;
        logic                      wb_en;
`ifdef ILLEGAL_INSN_TRAP_EN
        logic                      illegal;
`endif
    } entry_t;

    logic [5:0]  opcode;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [DATA_WIDTH-1:0] imm_sext;
    logic [DATA_WIDTH-1:0] imm_zext;
    logic        legal;
    logic        unused_rs_field;

    entry_t dec;
    entry_t m_q;
    entry_t s_q;
    logic   in_fire;
    logic   out_fire;

    assign opcode   = INSTR[31:26];
    assign rt       = INSTR[20:16];
    assign rd       = INSTR[15:11];
    assign shamt    = INSTR[10:6];
    assign funct    = INSTR[5:0];
    assign imm      = INSTR[15:0];
    assign imm_sext = {{(DATA_WIDTH-16){imm[15]}}, imm};
    assign imm_zext = {{(DATA_WIDTH-16){1'b0}}, imm};
    // The rs index is consumed by the register file upstream; only its data reaches us.
    assign unused_rs_field = ^INSTR[25:21];

    always_comb begin
        legal       = 1'b1;
        dec         = '0;
        dec.valid   = 1'b1;
        dec.oprn    = OPRN_WIDTH'(6'h20);
        dec.op1     = RS_DATA;
        dec.wb_addr = REG_ADDR_WIDTH'(rt);
        dec.wb_en   = 1'b1;
        case (opcode)
            6'h00: begin
                dec.wb_addr = REG_ADDR_WIDTH'(rd);
                dec.oprn    = OPRN_WIDTH'(funct);
                case (funct)
                    6'h20, 6'h22, 6'h2c, 6'h24, 6'h25, 6'h27, 6'h2a: dec.op2 = RT_DATA;
                    6'h01, 6'h02: begin
                        dec.op1 = RT_DATA;
                        dec.op2 = {{(DATA_WIDTH-5){1'b0}}, shamt};
                    end
                    default: legal = 1'b0;
                endcase
            end
            6'h08: dec.op2 = imm_sext;
            6'h1d: begin dec.oprn = OPRN_WIDTH'(6'h2c); dec.op2 = imm_sext; end
            6'h0a: begin dec.oprn = OPRN_WIDTH'(6'h2a); dec.op2 = imm_sext; end
            6'h0c: begin dec.oprn = OPRN_WIDTH'(6'h24); dec.op2 = imm_zext; end
            6'h0d: begin dec.oprn = OPRN_WIDTH'(6'h25); dec.op2 = imm_zext; end
            6'h0f: begin
                dec.oprn = OPRN_WIDTH'(6'h01);
                dec.op1  = imm_zext;
                dec.op2  = DATA_WIDTH'(16);
            end
            6'h23: dec.op2 = imm_sext;
            6'h2b: begin dec.op2 = imm_sext; dec.wb_en = 1'b0; end
            6'h04, 6'h05: begin
                dec.oprn  = OPRN_WIDTH'(6'h22);
                dec.op2   = RT_DATA;
                dec.wb_en = 1'b0;
            end
            default: legal = 1'b0;
        endcase
        // Undecodable words become an add of zeros that writes nothing back.
        if (!legal) begin
            dec         = '0;
            dec.valid   = 1'b1;
            dec.oprn    = OPRN_WIDTH'(6'h20);
`ifdef ILLEGAL_INSN_TRAP_EN
            dec.illegal = 1'b1;
`endif
        end
    end

    // IN_READY depends only on the skid register, so OUT_READY never reaches it combinationally.
    assign IN_READY  = ~s_q.valid;
    assign in_fire   = IN_VALID & IN_READY;
    assign out_fire  = m_q.valid & OUT_READY;

    always_ff @(posedge CLK) begin
        if (RST) begin
            m_q <= '0;
            s_q <= '0;
        end else if (FLUSH) begin
            m_q.valid <= 1'b0;
            s_q.valid <= 1'b0;
        end else if (s_q.valid && out_fire) begin
            m_q       <= s_q;
            s_q.valid <= 1'b0;
        end else if (in_fire && (!m_q.valid || out_fire)) begin
            m_q <= dec;
        end else if (in_fire) begin
            s_q <= dec;
        end else if (out_fire) begin
            m_q.valid <= 1'b0;
        end
    end

    assign OUT_VALID = m_q.valid;
    assign OP1       = m_q.op1;
    assign OP2       = m_q.op2;
    assign OPRN      = m_q.oprn;
    assign WB_ADDR   = m_q.wb_addr;
    assign WB_EN     = m_q.wb_en;
`ifdef ILLEGAL_INSN_TRAP_EN
    assign ILLEGAL   = m_q.illegal;
`endif

endmodule
